// File: rtl/exa_crosb_input_vc_arbiter.sv
// Per-input-port VC scheduler: strict priority with a starvation guard, round-robin
// within each level, and a whole-packet lock on the granted FIFO.
module exa_crosb_input_vc_arbiter #(
    parameter int unsigned prio_num     = 2,
    parameter int unsigned vc_num       = 2,
    parameter int unsigned output_num   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic [prio_num*vc_num-1:0]             i_has_packet,
    input  logic [prio_num*vc_num-1:0][((output_num > 1) ? $clog2(output_num) : 1)-1:0] i_dests,
    input  logic [prio_num*vc_num-1:0][((prio_num*vc_num > 1) ? $clog2(prio_num*vc_num) : 1)-1:0] i_out_vc,
    input  logic [output_num*prio_num*vc_num-1:0]  i_out_ready,
    input  logic                                   i_axis_tvalid,
    input  logic                                   i_axis_tlast,
    input  logic                                   i_axis_tready,
    output logic [((prio_num*vc_num > 1) ? $clog2(prio_num*vc_num) : 1)-1:0] o_selected_vc,
    output logic                                   o_cts,
    output logic                                   o_busy,
    output logic                                   o_starve_force
);

    localparam int unsigned PV        = prio_num * vc_num;
    localparam int unsigned logVcPrio = (PV > 1) ? $clog2(PV) : 1;
    localparam int unsigned logOutput = (output_num > 1) ? $clog2(output_num) : 1;
    localparam int unsigned IDX_W     = logOutput + logVcPrio + 1;
    localparam int unsigned NREADY    = output_num * PV;
    localparam int unsigned LOG_PRIO  = (prio_num > 1) ? $clog2(prio_num) : 1;
    localparam int unsigned LOG_VC    = (vc_num > 1) ? $clog2(vc_num) : 1;
    localparam int unsigned CNT_W     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                                state_q, state_d;
    logic [logVcPrio-1:0]                  sel_q, sel_d;
    logic                                  force_q, force_d;
    logic [CNT_W-1:0]                      starve_q, starve_d;
    logic [prio_num-1:0][LOG_VC-1:0]       rr_q, rr_d;

    logic [PV-1:0]                         elig;
    logic [prio_num-1:0][vc_num-1:0]       lvl_bits;
    logic [prio_num-1:0]                   lvl_elig;
    logic [LOG_PRIO-1:0]                   top_lvl, low_lvl, gnt_lvl, sel_lvl;
    logic                                  seen_top, low_any, force_grant;
    logic [vc_num-1:0]                     gnt_row, row_sh;
    logic [LOG_VC-1:0]                     rr_cur, pick, sel_loc;
    int                                    loc;
    logic                                  grant, hs_last;

    // FIFO eligibility: non-empty and the destination output VC can take a packet
    always_comb begin
        logic [IDX_W-1:0]  ready_idx;
        logic [NREADY-1:0] ready_sh;
        elig      = '0;
        ready_idx = '0;
        ready_sh  = '0;
        for (int k = 0; k < int'(PV); k++) begin
            ready_idx = IDX_W'(i_dests[k]) * IDX_W'(PV) + IDX_W'(i_out_vc[k]);
            ready_sh  = i_out_ready >> ready_idx;
            if (ready_idx < IDX_W'(NREADY)) begin
                elig[k] = i_has_packet[k] & ready_sh[0];
            end
        end
    end

    // Level selection (top level, or the next level down when starvation forces it) and RR pick
    always_comb begin
        lvl_bits = elig;
        lvl_elig = '0;
        top_lvl  = '0;
        low_lvl  = '0;
        seen_top = 1'b0;
        low_any  = 1'b0;
        pick     = '0;
        loc      = 0;
        row_sh   = '0;
        for (int l = 0; l < int'(prio_num); l++) begin
            lvl_elig[l] = |lvl_bits[l];
        end
        for (int l = int'(prio_num) - 1; l >= 0; l--) begin
            if (lvl_elig[l]) begin
                if (!seen_top) begin
                    top_lvl  = LOG_PRIO'(l);
                    seen_top = 1'b1;
                end else if (!low_any) begin
                    low_lvl = LOG_PRIO'(l);
                    low_any = 1'b1;
                end
            end
        end
        force_grant = low_any && (starve_q == CNT_W'(STARVE_LIMIT));
        gnt_lvl     = force_grant ? low_lvl : top_lvl;
        gnt_row     = lvl_bits[gnt_lvl];
        rr_cur      = rr_q[gnt_lvl];
        // Descending scan so the nearest candidate after rr_cur wins
        for (int j = int'(vc_num); j >= 1; j--) begin
            loc    = (int'(rr_cur) + j) % int'(vc_num);
            row_sh = gnt_row >> loc;
            if (row_sh[0]) begin
                pick = LOG_VC'(loc);
            end
        end
    end

    assign grant   = (state_q == IDLE) && (|elig);
    assign hs_last = (state_q == XFER) && i_axis_tvalid && i_axis_tready && i_axis_tlast;
    assign sel_lvl = LOG_PRIO'(int'(sel_q) / int'(vc_num));
    assign sel_loc = LOG_VC'(int'(sel_q) % int'(vc_num));

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            force_q  <= 1'b0;
            starve_q <= '0;
            for (int l = 0; l < int'(prio_num); l++) begin
                rr_q[l] <= LOG_VC'(vc_num - 1);
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            force_q  <= force_d;
            starve_q <= starve_d;
            rr_q     <= rr_d;
        end
    end

    // Next-state: lock on grant, release on the last-flit handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)   state_d = XFER;
            XFER:    if (hs_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping, starvation counter and round-robin pointer update
    always_comb begin
        sel_d    = sel_q;
        force_d  = force_q;
        starve_d = starve_q;
        rr_d     = rr_q;
        if (grant) begin
            sel_d   = logVcPrio'(int'(gnt_lvl) * int'(vc_num) + int'(pick));
            force_d = force_grant;
            if (force_grant) begin
                starve_d = '0;
            end else if (low_any) begin
                starve_d = (starve_q == CNT_W'(STARVE_LIMIT)) ? starve_q : starve_q + CNT_W'(1);
            end else begin
                starve_d = '0;
            end
        end
        if (hs_last) begin
            rr_d[sel_lvl] = sel_loc;
        end
    end

    assign o_selected_vc  = sel_q;
    assign o_starve_force = force_q;
    assign o_busy         = (state_q == XFER);
    assign o_cts          = (state_q == XFER) && i_axis_tvalid && i_axis_tready;

endmodule
